// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Bundles the writeback handshakes, the claim input, the register-file
// write port and the scoreboard output of regfile_wb_arbiter.
//   i_claim_valid/i_claim_addr   : destination reservation from issue
//   i_a_*, o_a_ready             : source A (ALU) writeback handshake
//   i_b_*, o_b_ready             : source B (load) writeback handshake
//   o_wr_enable/o_wr_addr/o_wr_data : registered register-file write port
//   o_pending                    : registered pending-write scoreboard
// The slave modport is the arbiter; the master modport is its environment.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5,
    parameter int DEPTH_P      = 32
);
    logic                    i_claim_valid;
    logic [ADDR_WIDTH_P-1:0] i_claim_addr;
    logic                    i_a_valid;
    logic [ADDR_WIDTH_P-1:0] i_a_addr;
    logic [DATA_WIDTH_P-1:0] i_a_data;
    logic                    o_a_ready;
    logic                    i_b_valid;
    logic [ADDR_WIDTH_P-1:0] i_b_addr;
    logic [DATA_WIDTH_P-1:0] i_b_data;
    logic                    o_b_ready;
    logic                    o_wr_enable;
    logic [ADDR_WIDTH_P-1:0] o_wr_addr;
    logic [DATA_WIDTH_P-1:0] o_wr_data;
    logic [DEPTH_P-1:0]      o_pending;

    modport slave (
        input  i_claim_valid, i_claim_addr,
        input  i_a_valid, i_a_addr, i_a_data,
        output o_a_ready,
        input  i_b_valid, i_b_addr, i_b_data,
        output o_b_ready,
        output o_wr_enable, o_wr_addr, o_wr_data,
        output o_pending
    );

    modport master (
        output i_claim_valid, i_claim_addr,
        output i_a_valid, i_a_addr, i_a_data,
        input  o_a_ready,
        output i_b_valid, i_b_addr, i_b_data,
        input  o_b_ready,
        input  o_wr_enable, o_wr_addr, o_wr_data,
        input  o_pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU (A) and load
// (B) writeback paths with round-robin arbitration, registers the winning
// write, drops writes to register 0 and keeps a per-register pending-write
// scoreboard for read-after-write stalls.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : regfile_wb_arbiter_if.slave (handshakes, claim, write port,
//           scoreboard)
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH_P = 32,
    parameter int ADDR_WIDTH_P = 5,
    parameter int DEPTH_P      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic                    last_grant_reg;
    logic                    last_grant_next;
    logic                    grant_a;
    logic                    grant_b;
    logic                    xfer;
    logic [ADDR_WIDTH_P-1:0] win_addr;
    logic [DATA_WIDTH_P-1:0] win_data;

    logic                    wr_enable_reg;
    logic [ADDR_WIDTH_P-1:0] wr_addr_reg;
    logic [DATA_WIDTH_P-1:0] wr_data_reg;
    logic [DEPTH_P-1:0]      pending_reg;
    logic [DEPTH_P-1:0]      pending_next;

    // Grants look only at the valids and the last winner so that ready never
    // depends on addr/data. Reset blocks any transfer in its own cycle.
    always_comb begin
        grant_a = bus.i_a_valid && (!bus.i_b_valid || (last_grant_reg == GRANT_B));
        grant_b = bus.i_b_valid && (!bus.i_a_valid || (last_grant_reg == GRANT_A));
        if (reset) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
        end
    end

    assign bus.o_a_ready = grant_a;
    assign bus.o_b_ready = grant_b;
    assign xfer          = grant_a || grant_b;
    assign win_addr      = grant_a ? bus.i_a_addr : bus.i_b_addr;
    assign win_data      = grant_a ? bus.i_a_data : bus.i_b_data;

    // Round-robin pointer only moves on an actual transfer.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (grant_a) begin
            last_grant_next = GRANT_A;
        end else if (grant_b) begin
            last_grant_next = GRANT_B;
        end
    end

    // Scoreboard: the set term is OR-ed after the clear term so a claim and a
    // retirement on the same register leave it reserved (new reservation).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH_P; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_bit
                logic set_bit;
                logic clr_bit;
                assign set_bit = bus.i_claim_valid && (bus.i_claim_addr == ADDR_WIDTH_P'(gi));
                assign clr_bit = xfer && (win_addr == ADDR_WIDTH_P'(gi));
                assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= GRANT_B;
            wr_enable_reg  <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            pending_reg    <= '0;
        end else begin
            last_grant_reg <= last_grant_next;
            wr_enable_reg  <= xfer && (win_addr != '0);
            // Address/data hold their last value on idle or register-0 cycles.
            if (xfer && (win_addr != '0)) begin
                wr_addr_reg <= win_addr;
                wr_data_reg <= win_data;
            end
            pending_reg <= pending_next;
        end
    end

    assign bus.o_wr_enable = wr_enable_reg;
    assign bus.o_wr_addr   = wr_addr_reg;
    assign bus.o_wr_data   = wr_data_reg;
    assign bus.o_pending   = pending_reg;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    regfile_wb_arbiter_if #(.DATA_WIDTH_P(32), .ADDR_WIDTH_P(5), .DEPTH_P(32)) bus ();

    regfile_wb_arbiter #(.DATA_WIDTH_P(32), .ADDR_WIDTH_P(5), .DEPTH_P(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        cv;
        logic [4:0]  ca;
        logic        ear;
        logic        ebr;
        logic        een;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [31:0] epend;
    } vec_t;

    vec_t vecs[14];

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                                logic bv, logic [4:0] ba, logic [31:0] bd,
                                logic cv, logic [4:0] ca, logic ear, logic ebr,
                                logic een, logic [4:0] ewa, logic [31:0] ewd,
                                logic [31:0] epend);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv; v.ba = ba; v.bd = bd;
        v.cv = cv; v.ca = ca;
        v.ear = ear; v.ebr = ebr;
        v.een = een; v.ewa = ewa; v.ewd = ewd; v.epend = epend;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                         input logic cv, input logic [4:0] ca);
        bus.i_a_valid = av; bus.i_a_addr = aa; bus.i_a_data = ad;
        bus.i_b_valid = bv; bus.i_b_addr = ba; bus.i_b_data = bd;
        bus.i_claim_valid = cv; bus.i_claim_addr = ca;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] m_pend;
        logic        m_last_b;
        logic        av, bv, cv, ea, eb, took_a, took_b;
        logic [4:0]  aa, ba, ca;
        logic [31:0] ad, bd;
        wr_t         w;

        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd7);
        #1;
        step();
        #1;
        check("ready_a_in_reset", {63'd0, bus.o_a_ready}, 64'd0);
        check("ready_b_in_reset", {63'd0, bus.o_b_ready}, 64'd0);
        step();
        check("rst_wr_enable", {63'd0, bus.o_wr_enable}, 64'd0);
        check("rst_wr_addr", {59'd0, bus.o_wr_addr}, 64'd0);
        check("rst_wr_data", {32'd0, bus.o_wr_data}, 64'd0);
        check("rst_pending", {32'd0, bus.o_pending}, 64'd0);
        reset = 1'b0;

        // ---------------- table-driven directed vectors ----------------
        vecs[0]  = mk(1, 3,  32'h11,   1, 4,  32'h22, 0, 0, 1, 0, 1, 3,  32'h11, 32'h0);
        vecs[1]  = mk(1, 3,  32'h11,   1, 4,  32'h22, 0, 0, 0, 1, 1, 4,  32'h22, 32'h0);
        vecs[2]  = mk(0, 0,  32'h0,    1, 5,  32'h55, 0, 0, 0, 1, 1, 5,  32'h55, 32'h0);
        vecs[3]  = mk(0, 0,  32'h0,    1, 6,  32'h66, 0, 0, 0, 1, 1, 6,  32'h66, 32'h0);
        vecs[4]  = mk(0, 0,  32'h0,    1, 7,  32'h77, 0, 0, 0, 1, 1, 7,  32'h77, 32'h0);
        vecs[5]  = mk(1, 0,  32'hFFFF, 0, 0,  32'h0,  0, 0, 1, 0, 0, 7,  32'h77, 32'h0);
        vecs[6]  = mk(0, 0,  32'h0,    0, 0,  32'h0,  1, 9, 0, 0, 0, 7,  32'h77, 32'h200);
        vecs[7]  = mk(0, 0,  32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 0, 7,  32'h77, 32'h200);
        vecs[8]  = mk(0, 0,  32'h0,    0, 0,  32'h0,  0, 0, 0, 0, 0, 7,  32'h77, 32'h200);
        vecs[9]  = mk(1, 9,  32'h99,   0, 0,  32'h0,  0, 0, 1, 0, 1, 9,  32'h99, 32'h0);
        vecs[10] = mk(1, 9,  32'h9A,   0, 0,  32'h0,  1, 9, 1, 0, 1, 9,  32'h9A, 32'h200);
        vecs[11] = mk(1, 10, 32'hA0,   1, 11, 32'hB0, 0, 0, 0, 1, 1, 11, 32'hB0, 32'h200);
        vecs[12] = mk(1, 10, 32'hA0,   1, 11, 32'hB0, 0, 0, 1, 0, 1, 10, 32'hA0, 32'h200);
        vecs[13] = mk(0, 0,  32'h0,    0, 0,  32'h0,  1, 0, 0, 0, 0, 10, 32'hA0, 32'h200);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
                  vecs[i].cv, vecs[i].ca);
            #1;
            check($sformatf("v%0d_a_ready", i), {63'd0, bus.o_a_ready}, {63'd0, vecs[i].ear});
            check($sformatf("v%0d_b_ready", i), {63'd0, bus.o_b_ready}, {63'd0, vecs[i].ebr});
            step();
            check($sformatf("v%0d_wr_enable", i), {63'd0, bus.o_wr_enable}, {63'd0, vecs[i].een});
            check($sformatf("v%0d_wr_addr", i), {59'd0, bus.o_wr_addr}, {59'd0, vecs[i].ewa});
            check($sformatf("v%0d_wr_data", i), {32'd0, bus.o_wr_data}, {32'd0, vecs[i].ewd});
            check($sformatf("v%0d_pending", i), {32'd0, bus.o_pending}, {32'd0, vecs[i].epend});
        end

        // ---------------- reset in the middle of traffic ----------------
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 2);
        step();
        drive(0, 0, 0, 0, 0, 0, 1, 3);
        step();
        check("seq_claims_pending", {32'd0, bus.o_pending}, 64'h0C);
        drive(1, 2, 32'h2222, 1, 4, 32'h44, 0, 0);
        #1;
        check("seq_tie_a_ready", {63'd0, bus.o_a_ready}, 64'd1);
        step();
        check("seq_wr_before_reset", {59'd0, bus.o_wr_addr}, 64'd2);
        check("seq_pending_cleared2", {32'd0, bus.o_pending}, 64'h08);
        reset = 1'b1;
        drive(1, 2, 32'h2323, 1, 4, 32'h44, 1, 5);
        #1;
        check("seq_reset_a_ready", {63'd0, bus.o_a_ready}, 64'd0);
        check("seq_reset_b_ready", {63'd0, bus.o_b_ready}, 64'd0);
        step();
        reset = 1'b0;
        check("seq_after_rst_en", {63'd0, bus.o_wr_enable}, 64'd0);
        check("seq_after_rst_pend", {32'd0, bus.o_pending}, 64'd0);
        bus.i_claim_valid = 1'b0;
        #1;
        check("seq_after_rst_a_wins", {63'd0, bus.o_a_ready}, 64'd1);
        check("seq_after_rst_b_waits", {63'd0, bus.o_b_ready}, 64'd0);
        step();
        check("seq_after_rst_wr_data", {32'd0, bus.o_wr_data}, 64'h2323);

        // ---------------- randomized traffic vs. reference model ----------------
        do_reset();
        m_pend = 32'd0;
        m_last_b = 1'b1;
        av = 0; bv = 0; aa = 0; ba = 0; ad = 0; bd = 0;
        took_a = 0; took_b = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!av || took_a) begin
                av = ($urandom_range(0, 99) < 60);
                aa = 5'($urandom_range(0, 31));
                ad = $urandom;
            end
            if (!bv || took_b) begin
                bv = ($urandom_range(0, 99) < 60);
                ba = 5'($urandom_range(0, 31));
                bd = $urandom;
            end
            cv = ($urandom_range(0, 99) < 40);
            ca = 5'($urandom_range(0, 31));
            drive(av, aa, ad, bv, ba, bd, cv, ca);
            #1;
            // Winner: sole requester, or on a tie whichever did not win last.
            ea = av && (!bv || m_last_b);
            eb = bv && (!av || !m_last_b);
            if (bus.o_a_ready && bus.o_b_ready)
                check("rnd_both_ready", 64'd1, 64'd0);
            check("rnd_a_ready", {63'd0, bus.o_a_ready}, {63'd0, ea});
            check("rnd_b_ready", {63'd0, bus.o_b_ready}, {63'd0, eb});
            took_a = ea;
            took_b = eb;
            if (ea || eb) begin
                w.addr = ea ? aa : ba;
                w.data = ea ? ad : bd;
                m_last_b = eb;
                if (w.addr != 5'd0) exp_q.push_back(w);
                m_pend[w.addr] = 1'b0;
            end
            if (cv) m_pend[ca] = 1'b1;
            m_pend[0] = 1'b0;
            step();
            if (bus.o_wr_enable) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_write", 64'd1, 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("rnd_wr_addr", {59'd0, bus.o_wr_addr}, {59'd0, w.addr});
                    check("rnd_wr_data", {32'd0, bus.o_wr_data}, {32'd0, w.data});
                end
            end
            if (exp_q.size() != 0) begin
                check("rnd_missing_write", {32'd0, 32'(exp_q.size())}, 64'd0);
                exp_q.delete();
            end
            check("rnd_pending", {32'd0, bus.o_pending}, {32'd0, m_pend});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
